// File: rtl/comparator_8bit_pkg.sv
// Shared types and constants for the registered 8-bit min/max comparator.
// Optional build macro: COMPARATOR_8BIT_SIGNED_EN (two's-complement compare mode).
package comparator_8bit_pkg;

    localparam int WIDTH  = 8;
    localparam int NIBBLE = 4;

    typedef logic [WIDTH-1:0] data_t;

    typedef struct packed {
        logic gt;
        logic eq;
    } cmp_flags_t;

    // The high nibble decides unless it is equal; then the low nibble decides.
    function automatic cmp_flags_t merge_flags(input cmp_flags_t hi, input cmp_flags_t lo);
        cmp_flags_t r;
        r.gt = hi.gt | (hi.eq & lo.gt);
        r.eq = hi.eq & lo.eq;
        return r;
    endfunction

endpackage

// File: rtl/comparator_8bit_core_if.sv
// Operand/result bundle for comparator_8bit_core.
// Optional build macro: COMPARATOR_8BIT_SIGNED_EN adds signed_mode.
//
// Handshake: in_valid=1 means A/B (and signed_mode) are valid and are accepted
// on that rising edge; there is no ready, every valid cycle is taken.
// out_valid=1 for exactly one cycle per accepted pair, one edge after sampling;
// Min/Max/a_gt_b/a_eq_b hold their last values while out_valid=0.
interface comparator_8bit_core_if;
    import comparator_8bit_pkg::*;

    logic  in_valid;
    data_t A;
    data_t B;
`ifdef COMPARATOR_8BIT_SIGNED_EN
    logic  signed_mode;
`endif
    logic  out_valid;
    data_t Min;
    data_t Max;
    logic  a_gt_b;
    logic  a_eq_b;

    modport master (
        output in_valid, A, B,
`ifdef COMPARATOR_8BIT_SIGNED_EN
        output signed_mode,
`endif
        input  out_valid, Min, Max, a_gt_b, a_eq_b
    );

    modport slave (
        input  in_valid, A, B,
`ifdef COMPARATOR_8BIT_SIGNED_EN
        input  signed_mode,
`endif
        output out_valid, Min, Max, a_gt_b, a_eq_b
    );

endinterface

// File: rtl/comparator_8bit_mag_cmp_4bit.sv
// Purely combinational 4-bit unsigned magnitude compare.
module mag_cmp_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       eq
);

    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/comparator_8bit_core.sv
// Registered 8-bit min/max comparator built from two cascaded nibble compares.
// Optional build macro: COMPARATOR_8BIT_SIGNED_EN enables two's-complement mode
// via bus.signed_mode; without it the compare is always unsigned.
module comparator_8bit_core
    import comparator_8bit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    comparator_8bit_core_if.slave bus
);

    // Compare keys: the operands, with the MSB flipped in signed mode so that
    // an unsigned magnitude compare orders two's-complement values correctly.
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    cmp_flags_t       hi_flags;
    cmp_flags_t       lo_flags;
    cmp_flags_t       flags;

    // Build the compare keys from the raw operands.
    always_comb begin
        a_key = bus.A;
        b_key = bus.B;
`ifdef COMPARATOR_8BIT_SIGNED_EN
        if (bus.signed_mode) begin
            a_key[WIDTH-1] = ~bus.A[WIDTH-1];
            b_key[WIDTH-1] = ~bus.B[WIDTH-1];
        end
`endif
    end

    mag_cmp_4bit u_cmp_hi (
        .a  (a_key[WIDTH-1 -: NIBBLE]),
        .b  (b_key[WIDTH-1 -: NIBBLE]),
        .gt (hi_flags.gt),
        .eq (hi_flags.eq)
    );

    mag_cmp_4bit u_cmp_lo (
        .a  (a_key[NIBBLE-1:0]),
        .b  (b_key[NIBBLE-1:0]),
        .gt (lo_flags.gt),
        .eq (lo_flags.eq)
    );

    assign flags = merge_flags(hi_flags, lo_flags);

    // Register results for each accepted pair; hold them while idle.
    // Min/Max take the original bytes, never the MSB-flipped keys.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.Min       <= '0;
            bus.Max       <= '0;
            bus.a_gt_b    <= 1'b0;
            bus.a_eq_b    <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.Min    <= flags.gt ? bus.B : bus.A;
                bus.Max    <= flags.gt ? bus.A : bus.B;
                bus.a_gt_b <= flags.gt;
                bus.a_eq_b <= flags.eq;
            end
        end
    end

endmodule

// File: tb/tb_comparator_8bit_core.sv
// Self-checking bench for comparator_8bit_core: reset, directed vector table,
// async mid-stream reset, back-to-back stream with idle hold, signed build cases.
module tb_comparator_8bit_core;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    comparator_8bit_core_if bus ();

    comparator_8bit_core #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic [7:0] exp_min;
        logic [7:0] exp_max;
        logic       exp_gt;
        logic       exp_eq;
    } vec_t;

    vec_t vecs[$];
    logic [17:0] exp_q[$];

    // Driver
    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic sm);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
`ifdef COMPARATOR_8BIT_SIGNED_EN
        bus.signed_mode = sm;
`else
        if (sm) $display("note: signed vector skipped in unsigned build");
`endif
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic ov, input logic [7:0] mn,
                             input logic [7:0] mx, input logic gt, input logic eq);
        check({name, ".out_valid"}, int'(bus.out_valid), int'(ov));
        check({name, ".Min"},       int'(bus.Min),       int'(mn));
        check({name, ".Max"},       int'(bus.Max),       int'(mx));
        check({name, ".a_gt_b"},    int'(bus.a_gt_b),    int'(gt));
        check({name, ".a_eq_b"},    int'(bus.a_eq_b),    int'(eq));
    endtask

    // Independent reference: plain integer ordering
    function automatic logic [17:0] ref_model(input logic [7:0] a, input logic [7:0] b, input logic sm);
        int ia;
        int ib;
        ia = sm ? int'($signed(a)) : int'(a);
        ib = sm ? int'($signed(b)) : int'(b);
        if (ia > ib)       return {b, a, 1'b1, 1'b0};
        else if (ia < ib)  return {a, b, 1'b0, 1'b0};
        else               return {a, a, 1'b0, 1'b1};
    endfunction

    initial begin
        logic [17:0] e;
        logic [7:0]  ra;
        logic [7:0]  rb;
        checks   = 0;
        failures = 0;

        // Hand-computed vectors: {A, B, signed_mode, Min, Max, gt, eq}
        vecs.push_back('{8'd31,  8'd230, 1'b0, 8'd31,  8'd230, 1'b0, 1'b0});
        vecs.push_back('{8'd134, 8'd127, 1'b0, 8'd127, 8'd134, 1'b1, 1'b0});
        vecs.push_back('{8'h57,  8'h53,  1'b0, 8'h53,  8'h57,  1'b1, 1'b0});
        vecs.push_back('{8'h53,  8'h57,  1'b0, 8'h53,  8'h57,  1'b0, 1'b0});
        vecs.push_back('{8'd136, 8'd136, 1'b0, 8'd136, 8'd136, 1'b0, 1'b1});
        vecs.push_back('{8'd0,   8'd255, 1'b0, 8'd0,   8'd255, 1'b0, 1'b0});
        vecs.push_back('{8'd255, 8'd0,   1'b0, 8'd0,   8'd255, 1'b1, 1'b0});
        vecs.push_back('{8'h10,  8'h0F,  1'b0, 8'h0F,  8'h10,  1'b1, 1'b0});
        vecs.push_back('{8'd0,   8'd0,   1'b0, 8'd0,   8'd0,   1'b0, 1'b1});
`ifdef COMPARATOR_8BIT_SIGNED_EN
        vecs.push_back('{8'h80,  8'h7F,  1'b1, 8'h80,  8'h7F,  1'b0, 1'b0});
        vecs.push_back('{8'h80,  8'h7F,  1'b0, 8'h7F,  8'h80,  1'b1, 1'b0});
        vecs.push_back('{8'hFF,  8'h01,  1'b1, 8'hFF,  8'h01,  1'b0, 1'b0});
        vecs.push_back('{8'hFE,  8'hFF,  1'b1, 8'hFE,  8'hFF,  1'b0, 1'b0});
`endif

        // Reset held with valid traffic present: outputs stay zero
        rst_n = 1'b0;
        drive(1'b1, 8'd5, 8'd9, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold", 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        rst_n = 1'b1;

        // Directed table, one pair per cycle
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sm);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), 1'b1, vecs[i].exp_min, vecs[i].exp_max,
                      vecs[i].exp_gt, vecs[i].exp_eq);
        end

        // Async reset mid-cycle after valid traffic clears outputs at once
        @(negedge clk);
        drive(1'b1, 8'd200, 8'd100, 1'b0);
        @(posedge clk);
        #1;
        check_all("pre_async", 1'b1, 8'd100, 8'd200, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

        // First pair after reset release is processed normally
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'd9, 8'd5, 1'b0);
        @(posedge clk);
        #1;
        check_all("first_after_reset", 1'b1, 8'd5, 8'd9, 1'b1, 1'b0);

        // Back-to-back random stream against the reference model
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ra = 8'($urandom_range(0, 255));
            rb = (i == 3) ? ra : 8'($urandom_range(0, 255));
            drive(1'b1, ra, rb, 1'b0);
            exp_q.push_back(ref_model(ra, rb, 1'b0));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check_all($sformatf("stream%0d", i), 1'b1, e[17:10], e[9:2], e[1], e[0]);
        end

        // Idle: outputs hold the last result, out_valid low, inputs ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
            @(posedge clk);
            #1;
            check_all($sformatf("idle%0d", i), 1'b0, e[17:10], e[9:2], e[1], e[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
